dab_gate_deadtime: RTL and testbench

- Downstream stage of the DAB phase-shift modulator. Converts the three-level bridge voltage commands v1/v2 (-1/0/+1) into eight gate signals: Sp[3:0] for the primary H-bridge and Ss[3:0] for the secondary H-bridge.
- Inserts a programmable dead time on every leg transition, guaranteeing no shoot-through.
- Provides a sticky fault shutdown and an enable gate.
- Outputs drive the gate-driver pins directly.

---
 rtl/dab_pkg.sv | 30 +++
 rtl/dt_leg.sv | 98 +++++++++
 rtl/dab_gate_deadtime.sv | 85 ++++++++
 tb/tb_dab_gate_deadtime.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dab_pkg.sv
// Shared encodings for the DAB gate/dead-time stage: bridge levels, leg states
// and the level-to-leg decode used by the top level.
package dab_pkg;

    localparam logic signed [1:0] V_POS  = 2'sb01;
    localparam logic signed [1:0] V_ZERO = 2'sb00;
    localparam logic signed [1:0] V_NEG  = 2'sb11;

    localparam int DT_W_DEF = 8;

    typedef enum logic [1:0] {
        LEG_OFF   = 2'd0,
        LEG_DEAD  = 2'd1,
        LEG_HI_ON = 2'd2,
        LEG_LO_ON = 2'd3
    } leg_state_e;

    // Returns {leg B wants high, leg A wants high}; 2'b10 falls into the
    // freewheel case together with zero.
    function automatic logic [1:0] level_to_leg(input logic signed [1:0] v);
        logic [1:0] r;
        case (v)
            V_POS:   r = 2'b01;
            V_NEG:   r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dt_leg.sv
// One half-bridge leg: OFF/DEAD/HI_ON/LO_ON state machine with a dead-time
// down-counter and registered, mutually exclusive high/low gate outputs.
module dt_leg
    import dab_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce_i,
    input  logic            kill_i,
    input  logic            cmd_hi_i,
    input  logic [DT_W-1:0] dt_i,
    output logic            hi_o,
    output logic            lo_o,
    output logic            dead_o
);

    localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);

    leg_state_e      state_q, state_d;
    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            hi_q, hi_d;
    logic            lo_q, lo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LEG_OFF;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Kill acts on every clk edge; normal sequencing only on CE edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill_i) begin
            state_d = LEG_OFF;
            cnt_d   = '0;
        end else if (ce_i) begin
            case (state_q)
                LEG_OFF: begin
                    state_d = LEG_DEAD;
                    cnt_d   = dt_i;
                end
                LEG_DEAD: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = cmd_hi_i ? LEG_HI_ON : LEG_LO_ON;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                LEG_HI_ON: begin
                    if (!cmd_hi_i) begin
                        state_d = LEG_DEAD;
                        cnt_d   = dt_i;
                    end
                end
                LEG_LO_ON: begin
                    if (cmd_hi_i) begin
                        state_d = LEG_DEAD;
                        cnt_d   = dt_i;
                    end
                end
                default: begin
                    state_d = LEG_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Gates follow the current state one edge later, so a leaving gate
    // always drops before the opposite one can be granted.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (kill_i) begin
            hi_d = 1'b0;
            lo_d = 1'b0;
        end else if (ce_i) begin
            hi_d = (state_q == LEG_HI_ON);
            lo_d = (state_q == LEG_LO_ON);
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign dead_o = (state_q == LEG_DEAD);

endmodule

// File: rtl/dab_gate_deadtime.sv
// DAB gate stage: registers the two bridge level commands, decodes them into
// four leg commands, and drives eight gates through dead-time leg FSMs.
module dab_gate_deadtime
    import dab_pkg::*;
#(
    parameter int DT_W   = DT_W_DEF,
    parameter int DT_MIN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CE,
    input  logic              en,
    input  logic              fault_in,
    input  logic              fault_clr,
    input  logic [DT_W-1:0]   deadtime,
    input  logic signed [1:0] v1,
    input  logic signed [1:0] v2,
    output logic [3:0]        Sp,
    output logic [3:0]        Ss,
    output logic              fault,
    output logic              dead_active
);

    localparam logic [DT_W-1:0] DT_MIN_W = DT_W'(DT_MIN);

    logic signed [1:0] v1_q, v2_q;
    logic              fault_q, fault_d;
    logic              kill;
    logic [DT_W-1:0]   dt_eff;
    logic [1:0]        lv1, lv2;
    logic [3:0]        leg_cmd_hi;
    logic [3:0]        leg_hi, leg_lo, leg_dead;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= V_ZERO;
            v2_q <= V_ZERO;
        end else if (CE) begin
            v1_q <= v1;
            v2_q <= v2;
        end
    end

    // Fault latch runs on every clk so a pulse during CE=0 is never missed;
    // a simultaneous set and clear keeps the fault.
    assign fault_d = fault_in | (fault_q & ~fault_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign kill   = ~en | fault_in | fault_q;
    assign dt_eff = (deadtime < DT_MIN_W) ? DT_MIN_W : deadtime;

    assign lv1        = level_to_leg(v1_q);
    assign lv2        = level_to_leg(v2_q);
    assign leg_cmd_hi = {lv2[1], lv2[0], lv1[1], lv1[0]};

    // Leg order: 0 primary A, 1 primary B, 2 secondary A, 3 secondary B.
    for (genvar g = 0; g < 4; g++) begin : g_leg
        dt_leg #(
            .DT_W (DT_W)
        ) u_leg (
            .clk      (clk),
            .rst      (rst),
            .ce_i     (CE),
            .kill_i   (kill),
            .cmd_hi_i (leg_cmd_hi[g]),
            .dt_i     (dt_eff),
            .hi_o     (leg_hi[g]),
            .lo_o     (leg_lo[g]),
            .dead_o   (leg_dead[g])
        );
    end

    assign Sp          = {leg_lo[1], leg_hi[1], leg_lo[0], leg_hi[0]};
    assign Ss          = {leg_lo[3], leg_hi[3], leg_lo[2], leg_hi[2]};
    assign fault       = fault_q;
    assign dead_active = |leg_dead;

endmodule

// File: tb/tb_dab_gate_deadtime.sv
// Directed bench for dab_gate_deadtime: start-up, leg transitions, dead-time
// floor, fault/enable kill, CE freeze and the no-shoot-through invariant.
module tb_dab_gate_deadtime;

    logic              clk = 1'b0;
    logic              rst;
    logic              CE;
    logic              en;
    logic              fault_in;
    logic              fault_clr;
    logic [7:0]        deadtime;
    logic signed [1:0] v1;
    logic signed [1:0] v2;
    logic [3:0]        Sp;
    logic [3:0]        Ss;
    logic              fault;
    logic              dead_active;

    int   n_pass  = 0;
    int   n_total = 0;
    logic shoot_thru = 1'b0;

    dab_gate_deadtime #(
        .DT_W   (8),
        .DT_MIN (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .CE          (CE),
        .en          (en),
        .fault_in    (fault_in),
        .fault_clr   (fault_clr),
        .deadtime    (deadtime),
        .v1          (v1),
        .v2          (v2),
        .Sp          (Sp),
        .Ss          (Ss),
        .fault       (fault),
        .dead_active (dead_active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if ((Sp[0] & Sp[1]) | (Sp[2] & Sp[3]) | (Ss[0] & Ss[1]) | (Ss[2] & Ss[3]))
                shoot_thru = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; CE = 1'b1; en = 1'b1; fault_in = 1'b0; fault_clr = 1'b0;
        deadtime = 8'd4; v1 = 2'sb00; v2 = 2'sb00;
        repeat (3) tick();
        n_total++; if (Sp !== 4'b0000) $display("FAIL reset_sp: got %b want %b", Sp, 4'b0000); else n_pass++;
        n_total++; if (Ss !== 4'b0000) $display("FAIL reset_ss: got %b want %b", Ss, 4'b0000); else n_pass++;
        n_total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else n_pass++;
        n_total++; if (dead_active !== 1'b0) $display("FAIL reset_dead: got %b want 0", dead_active); else n_pass++;
    endtask

    task automatic test_startup();
        rst = 1'b0;
        tick();
        n_total++; if (dead_active !== 1'b1) $display("FAIL start_dead_active: got %b want 1", dead_active); else n_pass++;
        n_total++; if (Sp !== 4'b0000) $display("FAIL start_sp_entry: got %b want 0000", Sp); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (Sp !== 4'b0000 || Ss !== 4'b0000)
                $display("FAIL start_dead_gates[%0d]: Sp=%b Ss=%b want 0000/0000", i, Sp, Ss);
            else n_pass++;
        end
        n_total++; if (dead_active !== 1'b0) $display("FAIL start_dead_done: got %b want 0", dead_active); else n_pass++;
        tick();
        n_total++; if (Sp !== 4'b1010) $display("FAIL start_sp_on: got %b want 1010", Sp); else n_pass++;
        n_total++; if (Ss !== 4'b1010) $display("FAIL start_ss_on: got %b want 1010", Ss); else n_pass++;
    endtask

    task automatic test_step();
        deadtime = 8'd5; v1 = 2'sb01;
        tick();
        tick();
        n_total++; if (Sp !== 4'b1010) $display("FAIL step_k1: got %b want 1010", Sp); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if (Sp !== 4'b1000) $display("FAIL step_dead[%0d]: got %b want 1000", i, Sp); else n_pass++;
        end
        tick();
        n_total++; if (Sp !== 4'b1001) $display("FAIL step_hi_on: got %b want 1001", Sp); else n_pass++;
        n_total++; if (Ss !== 4'b1010) $display("FAIL step_ss_untouched: got %b want 1010", Ss); else n_pass++;
    endtask

    task automatic test_revert();
        deadtime = 8'd6; v1 = 2'sb00;
        tick();
        v1 = 2'sb01;
        tick();
        n_total++; if (Sp !== 4'b1001) $display("FAIL revert_k1: got %b want 1001", Sp); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_total++;
            if (Sp !== 4'b1000) $display("FAIL revert_dead[%0d]: got %b want 1000", i, Sp); else n_pass++;
        end
        tick();
        n_total++; if (Sp !== 4'b1001) $display("FAIL revert_back_hi: got %b want 1001", Sp); else n_pass++;
    endtask

    task automatic test_both_legs();
        deadtime = 8'd0; v2 = 2'sb11;
        repeat (4) tick();
        n_total++; if (Ss !== 4'b0110) $display("FAIL both_neg_settle: got %b want 0110", Ss); else n_pass++;
        v2 = 2'sb01;
        tick();
        tick();
        n_total++; if (Ss !== 4'b0110) $display("FAIL both_k1: got %b want 0110", Ss); else n_pass++;
        n_total++; if (dead_active !== 1'b1) $display("FAIL both_dead_active: got %b want 1", dead_active); else n_pass++;
        tick();
        n_total++; if (Ss !== 4'b0000) $display("FAIL both_one_dead: got %b want 0000", Ss); else n_pass++;
        tick();
        n_total++; if (Ss !== 4'b1001) $display("FAIL both_pos_on: got %b want 1001", Ss); else n_pass++;
        n_total++; if (Sp !== 4'b1001) $display("FAIL both_sp_untouched: got %b want 1001", Sp); else n_pass++;
    endtask

    task automatic test_level_10();
        v1 = 2'sb10;
        repeat (4) tick();
        n_total++; if (Sp !== 4'b1010) $display("FAIL lvl10_as_zero: got %b want 1010", Sp); else n_pass++;
    endtask

    task automatic test_fault();
        CE = 1'b0; fault_in = 1'b1;
        tick();
        n_total++; if (Sp !== 4'b0000 || Ss !== 4'b0000)
            $display("FAIL fault_kill_ce0: Sp=%b Ss=%b want 0000/0000", Sp, Ss); else n_pass++;
        n_total++; if (fault !== 1'b1) $display("FAIL fault_set: got %b want 1", fault); else n_pass++;
        CE = 1'b1; fault_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (Sp !== 4'b0000 || Ss !== 4'b0000 || fault !== 1'b1)
                $display("FAIL fault_hold[%0d]: Sp=%b Ss=%b fault=%b want 0000/0000/1", i, Sp, Ss, fault);
            else n_pass++;
        end
        fault_in = 1'b1; fault_clr = 1'b1;
        tick();
        n_total++; if (fault !== 1'b1) $display("FAIL fault_set_wins: got %b want 1", fault); else n_pass++;
        fault_in = 1'b0;
        tick();
        n_total++; if (fault !== 1'b0) $display("FAIL fault_clear: got %b want 0", fault); else n_pass++;
        fault_clr = 1'b0;
        tick();
        n_total++; if (Sp !== 4'b0000 || dead_active !== 1'b1)
            $display("FAIL fault_reentry_dead: Sp=%b dead=%b want 0000/1", Sp, dead_active); else n_pass++;
        tick();
        n_total++; if (Sp !== 4'b0000) $display("FAIL fault_reentry_gap: got %b want 0000", Sp); else n_pass++;
        tick();
        n_total++; if (Sp !== 4'b1010 || Ss !== 4'b1001)
            $display("FAIL fault_reentry_on: Sp=%b Ss=%b want 1010/1001", Sp, Ss); else n_pass++;
    endtask

    task automatic test_ce_freeze();
        deadtime = 8'd3; v1 = 2'sb01;
        tick();
        tick();
        n_total++; if (Sp !== 4'b1010 || dead_active !== 1'b1)
            $display("FAIL freeze_entry: Sp=%b dead=%b want 1010/1", Sp, dead_active); else n_pass++;
        tick();
        n_total++; if (Sp !== 4'b1000) $display("FAIL freeze_low_drop: got %b want 1000", Sp); else n_pass++;
        CE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_total++;
            if (Sp !== 4'b1000 || dead_active !== 1'b1)
                $display("FAIL freeze_hold[%0d]: Sp=%b dead=%b want 1000/1", i, Sp, dead_active);
            else n_pass++;
        end
        CE = 1'b1;
        tick();
        n_total++; if (Sp !== 4'b1000) $display("FAIL freeze_c1: got %b want 1000", Sp); else n_pass++;
        tick();
        n_total++; if (Sp !== 4'b1000) $display("FAIL freeze_c2: got %b want 1000", Sp); else n_pass++;
        tick();
        n_total++; if (Sp !== 4'b1001) $display("FAIL freeze_done: got %b want 1001", Sp); else n_pass++;
    endtask

    task automatic test_enable();
        en = 1'b0;
        tick();
        n_total++; if (Sp !== 4'b0000 || Ss !== 4'b0000 || fault !== 1'b0)
            $display("FAIL en_off: Sp=%b Ss=%b fault=%b want 0000/0000/0", Sp, Ss, fault); else n_pass++;
        en = 1'b1;
        tick();
        n_total++; if (dead_active !== 1'b1) $display("FAIL en_reentry_dead: got %b want 1", dead_active); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (Sp !== 4'b0000 || Ss !== 4'b0000)
                $display("FAIL en_dead[%0d]: Sp=%b Ss=%b want 0000/0000", i, Sp, Ss);
            else n_pass++;
        end
        tick();
        n_total++; if (Sp !== 4'b1001 || Ss !== 4'b1001)
            $display("FAIL en_on: Sp=%b Ss=%b want 1001/1001", Sp, Ss); else n_pass++;
    endtask

    task automatic test_async_reset();
        tick();
        #2 rst = 1'b1;
        #1;
        n_total++; if (Sp !== 4'b0000 || Ss !== 4'b0000 || dead_active !== 1'b0)
            $display("FAIL async_reset: Sp=%b Ss=%b dead=%b want 0000/0000/0", Sp, Ss, dead_active); else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_invariant();
        n_total++;
        if (shoot_thru !== 1'b0) $display("FAIL no_shoot_through: got %b want 0", shoot_thru); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_step();
        test_revert();
        test_both_legs();
        test_level_10();
        test_fault();
        test_ce_freeze();
        test_enable();
        test_async_reset();
        test_invariant();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
